// File: rtl/timestamp_extraction.sv
// timestamp_extraction: strip SOP tuser timestamp, forward via register slice, emit {byte_count, ts} stamp records
module timestamp_extraction #(
  parameter int TIMESTAMP_WIDTH      = 64,
  parameter int TIMESTAMP_POS        = 32,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int CLEAR_TIMESTAMP      = 1,
  parameter int STAMP_DEPTH_BITS     = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [C_M_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_M_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb,
  input  logic                                s_axis_tvalid,
  input  logic                                s_axis_tlast,
  output logic                                s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_tready,
  output logic [16+TIMESTAMP_WIDTH-1:0]       m_stamp_tdata,
  output logic                                m_stamp_tvalid,
  input  logic                                m_stamp_tready,
  output logic [31:0]                         pkt_count
);
  localparam int SW = C_M_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_M_AXIS_TUSER_WIDTH;
  localparam int RW = 16 + TIMESTAMP_WIDTH;
  localparam int CW = STAMP_DEPTH_BITS + 1;
  localparam logic [UW-1:0] TS_MASK = ((UW'(1) << TIMESTAMP_WIDTH) - UW'(1)) << TIMESTAMP_POS;
  typedef enum logic {SOP, IN_PKT} state_t;
  state_t                    state_q, state_d;
  logic [C_M_AXIS_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [UW-1:0]             tuser_q, tuser_d;
  logic [SW-1:0]             tstrb_q, tstrb_d;
  logic                      tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [15:0]               acc_q, acc_d;
  logic [TIMESTAMP_WIDTH-1:0] ts_q, ts_d, ts_in, ts_cur;
  logic [STAMP_DEPTH_BITS-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [31:0]               pkt_q, pkt_d;
  logic [RW-1:0]             mem [2**STAMP_DEPTH_BITS];
  logic [5:0]                pc;
  logic [16:0]               sum;
  logic                      accept, sop, push, pop;
  assign s_axis_tready  = (!tvalid_q || m_axis_tready) && !cnt_q[STAMP_DEPTH_BITS];
  assign m_axis_tdata   = tdata_q;
  assign m_axis_tuser   = tuser_q;
  assign m_axis_tstrb   = tstrb_q;
  assign m_axis_tvalid  = tvalid_q;
  assign m_axis_tlast   = tlast_q;
  assign m_stamp_tvalid = cnt_q != '0;
  assign m_stamp_tdata  = m_stamp_tvalid ? mem[rd_q] : '0;
  assign pkt_count      = pkt_q;
  // bytes carried by the incoming beat (holes counted, no contiguity check)
  always_comb begin
    pc = '0;
    for (int i = 0; i < SW; i++) pc = pc + 6'(s_axis_tstrb[i]);
  end
  // next-state: packet FSM, saturating byte accumulator, output slice, stamp FIFO pointers
  always_comb begin
    accept   = s_axis_tvalid && s_axis_tready;
    sop      = state_q == SOP;
    ts_in    = s_axis_tuser[TIMESTAMP_POS +: TIMESTAMP_WIDTH];
    ts_cur   = sop ? ts_in : ts_q;
    sum      = (sop ? 17'd0 : {1'b0, acc_q}) + 17'(pc);
    push     = accept && s_axis_tlast;
    pop      = m_stamp_tvalid && m_stamp_tready;
    state_d  = accept ? (s_axis_tlast ? SOP : IN_PKT) : state_q;
    acc_d    = accept ? (sum[16] ? 16'hFFFF : sum[15:0]) : acc_q;
    ts_d     = (accept && sop) ? ts_in : ts_q;
    tvalid_d = accept || (tvalid_q && !m_axis_tready);
    tdata_d  = accept ? s_axis_tdata : tdata_q;
    tstrb_d  = accept ? s_axis_tstrb : tstrb_q;
    tlast_d  = accept ? s_axis_tlast : tlast_q;
    tuser_d  = !accept ? tuser_q : (sop && CLEAR_TIMESTAMP != 0) ? (s_axis_tuser & ~TS_MASK) : s_axis_tuser;
    wr_d     = wr_q + STAMP_DEPTH_BITS'(push);
    rd_d     = rd_q + STAMP_DEPTH_BITS'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    pkt_d    = pkt_q + 32'(push);
  end
  // state registers; reset abandons any partial packet
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SOP;
      tdata_q  <= '0;
      tuser_q  <= '0;
      tstrb_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      acc_q    <= '0;
      ts_q     <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      pkt_q    <= '0;
    end else begin
      state_q  <= state_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tstrb_q  <= tstrb_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      acc_q    <= acc_d;
      ts_q     <= ts_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      pkt_q    <= pkt_d;
    end
  end
  // stamp FIFO storage; the record includes the tlast beat's bytes
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= {acc_d, ts_cur};
  end
endmodule
